// File: rtl/scan_sequencer_pkg.sv
// Shared constants and FSM encoding for the channel scan sequencer.
package scan_sequencer_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

endpackage

// File: rtl/next_chan_pick.sv
// Combinational next-channel picker: lowest set mask index above cur, else
// wrap to the lowest set index.
module next_chan_pick
  import scan_sequencer_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrapped
);

  logic             found_hi;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;

  // Descending scan so the last hit written is the lowest qualifying index.
  always_comb begin
    found_hi = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo_idx = SEL_W'(i);
        if (i > int'(cur)) begin
          hi_idx   = SEL_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    nxt     = found_hi ? hi_idx : lo_idx;
    wrapped = ~found_hi;
  end

endmodule

// File: rtl/scan_sequencer.sv
// Round-robin scan over masked channels with a per-channel dwell down-counter,
// driving a 3x8 decoder through registered sel/en.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N_CH-1:0]    chan_mask,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic               one_shot_q, one_shot_d;
  logic [SEL_W-1:0]   sel_d;
  logic               en_d, busy_d, done_d, wrap_d;

  logic [N_CH-1:0]    pick_mask;
  logic [SEL_W-1:0]   pick_cur;
  logic [SEL_W-1:0]   pick_nxt;
  logic               pick_wrapped;

  // In IDLE, asking for the successor of the top channel yields the lowest set bit.
  always_comb begin
    pick_mask = (state_q == IDLE) ? chan_mask : mask_q;
    pick_cur  = (state_q == IDLE) ? SEL_W'(N_CH - 1) : sel;
  end

  next_chan_pick u_pick (
    .mask    (pick_mask),
    .cur     (pick_cur),
    .nxt     (pick_nxt),
    .wrapped (pick_wrapped)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    mask_d     = mask_q;
    one_shot_d = one_shot_q;
    sel_d      = '0;
    en_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && (chan_mask != '0)) begin
          state_d    = DWELL;
          mask_d     = chan_mask;
          dwell_d    = dwell;
          one_shot_d = one_shot;
          cnt_d      = dwell;
          sel_d      = pick_nxt;
          en_d       = 1'b1;
          busy_d     = 1'b1;
        end
      end
      DWELL: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d  = cnt_q - DWELL_W'(1);
          sel_d  = sel;
          en_d   = 1'b1;
          busy_d = 1'b1;
        end else if (pick_wrapped && one_shot_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = dwell_q;
          sel_d  = pick_nxt;
          en_d   = 1'b1;
          busy_d = 1'b1;
          wrap_d = pick_wrapped;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dwell_q    <= '0;
      mask_q     <= '0;
      one_shot_q <= 1'b0;
      sel        <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      mask_q     <= mask_d;
      one_shot_q <= one_shot_d;
      sel        <= sel_d;
      en         <= en_d;
      busy       <= busy_d;
      done       <= done_d;
      wrap       <= wrap_d;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: time-indexed behavioural model checked every cycle,
// plus directed sequences with literal expectations.
module tb_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, stop, one_shot;
  logic [7:0] dwell;
  logic [7:0] chan_mask;
  logic [2:0] sel;
  logic       en, busy, done, wrap;

  int checks = 0;
  int errors = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .one_shot  (one_shot),
    .dwell     (dwell),
    .chan_mask (chan_mask),
    .sel       (sel),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a scan is the list of set channels, t counts cycles since entry.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_os     = 1'b0;
  int m_list[8];
  int m_n = 0;
  int m_d = 0;
  int m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (stop) begin
          m_active = 1'b0;
        end else begin
          m_t++;
          if (m_os && m_t == m_n * (m_d + 1)) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (start && !stop && chan_mask != 8'h00) begin
        m_n = 0;
        for (int i = 0; i < 8; i++) begin
          if (chan_mask[i]) begin
            m_list[m_n] = i;
            m_n++;
          end
        end
        m_d      = int'(dwell);
        m_os     = one_shot;
        m_t      = 0;
        m_active = 1'b1;
      end
    end
  end

  logic [2:0] e_sel;
  logic       e_en, e_busy, e_wrap;

  always @(negedge clk) begin
    e_sel  = 3'd0;
    e_en   = 1'b0;
    e_busy = 1'b0;
    e_wrap = 1'b0;
    if (m_active) begin
      e_sel  = 3'(m_list[(m_t / (m_d + 1)) % m_n]);
      e_en   = 1'b1;
      e_busy = 1'b1;
      e_wrap = !m_os && (m_t > 0) && ((m_t % (m_n * (m_d + 1))) == 0);
    end
    chk("model_sel_en_busy_done_wrap", {27'd0, sel, en, busy, done, wrap},
        {27'd0, e_sel, e_en, e_busy, m_done, e_wrap});
    chk("en_implies_busy", 32'(en & ~busy), 32'd0);
  end

  task automatic wait_sel(input logic [2:0] target);
    int n = 0;
    while (sel !== target && n < 200) begin
      tick();
      n++;
    end
    chk("wait_sel", 32'(sel), 32'(target));
  endtask

  int exp34[8]  = '{0, 0, 2, 2, 5, 5, 7, 7};
  int exp35s[5] = '{0, 7, 0, 7, 0};
  int exp35w[5] = '{0, 0, 1, 0, 1};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
    dwell = 8'd0; chan_mask = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sel", 32'(sel), 0);
    chk("reset_en_busy", 32'({en, busy, done, wrap}), 0);
    #2 rst_n = 1'b1;
    tick();

    // one-shot pass over 0,2,5,7 with two cycles each
    chan_mask = 8'hA5; dwell = 8'd1; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("p034_sel", 32'(sel), exp34[i]);
      chk("p034_en_busy_done", 32'({en, busy, done}), 32'(3'b110));
      tick();
    end
    chk("p034_done", 32'({en, busy, done}), 32'(3'b001));
    tick();
    chk("p034_done_pulse", 32'(done), 0);

    // continuous two-channel alternation with wrap
    chan_mask = 8'h81; dwell = 8'd0; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("p035_sel", 32'(sel), exp35s[i]);
      chk("p035_wrap", 32'(wrap), exp35w[i]);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("p035_stop", 32'({sel, en, busy}), 0);

    // empty mask ignored, then single channel
    chan_mask = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("p036_empty", 32'({en, busy, done}), 0);
    chan_mask = 8'h10; start = 1'b1;
    tick();
    start = 1'b0;
    chk("p036_sel4", 32'(sel), 4);
    chk("p036_en", 32'({en, wrap}), 32'(2'b10));
    tick();
    chk("p036_single_wrap", 32'({sel, wrap}), 32'({3'd4, 1'b1}));
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // stop mid-scan, then start+stop together from IDLE
    chan_mask = 8'hFF; dwell = 8'd3; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_sel(3'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("p037_stop", 32'({sel, en, busy}), 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("p037_start_stop", 32'({en, busy}), 0);

    // async reset mid-dwell
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sel(3'd5);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("p038_reset_now", 32'({sel, en, busy, done, wrap}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    tick();
    chk("p038_after_release", 32'({sel, en, busy}), 0);

    // changes during a scan have no effect
    chan_mask = 8'hA5; dwell = 8'd1; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("p039_sel", 32'(sel), exp34[i]);
      start = (i == 3);
      if (i == 3) begin
        chan_mask = 8'hFF; dwell = 8'd0; one_shot = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("p039_done", 32'({busy, done}), 32'(2'b01));
    tick();

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 40) == 0);
      chan_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      dwell     = 8'($urandom_range(0, 3));
      one_shot  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 300) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0; stop = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
